// File: rtl/param_icache_pkg.sv
// ============================================================================
// Module   : param_icache_pkg
// Brief    : Shared types and constants for the parametrised instruction cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package param_icache_pkg;

  localparam int ICACHE_WAYS_MAX = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [0:0] {
    ACCESS = 1'b0,
    FILL   = 1'b1
  } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/param_icache_if.sv
// ============================================================================
// Module   : param_icache_if
// Brief    : Fetch-port and memory-arbiter signal bundle for param_icache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_icache_if #(
  parameter int ADDR_W = 32
);
  import param_icache_pkg::*;

  logic              imemREN;
  logic [ADDR_W-1:0] imemaddr;
  logic              ihit;
  word_t             imemload;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  word_t             iload;

  // The cache is the slave; the environment (datapath + arbiter) is the master.
  modport slave  (input  imemREN, imemaddr, iwait, iload,
                  output ihit, imemload, iREN, iaddr);
  modport master (output imemREN, imemaddr, iwait, iload,
                  input  ihit, imemload, iREN, iaddr);

endinterface

`default_nettype wire

// File: rtl/param_icache_way.sv
// ============================================================================
// Module   : param_icache_way
// Brief    : One cache way: SETS frames with tag compare and word-select mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_icache_way
  import param_icache_pkg::*;
#(
  parameter  int SETS     = 8,
  parameter  int BLKWORDS = 2,
  parameter  int TAG_W    = 26,
  localparam int IDX_W    = $clog2(SETS),
  localparam int OFF_WS   = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic [OFF_WS-1:0] rd_off,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              inval,
  input  logic              wr_en,
  input  logic [OFF_WS-1:0] wr_off,
  input  word_t             wr_data,
  input  logic              fill_done,
  input  logic [TAG_W-1:0]  wr_tag,
  output logic              hit,
  output logic              valid,
  output word_t             rd_word
);

  typedef struct packed {
    logic                      valid;
    logic [TAG_W-1:0]          tag;
    word_t [BLKWORDS-1:0]      data;
  } frame_t;

  frame_t r_frames [SETS];

  // Only the valid bits need reset; tag/data are qualified by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_frames[s].valid <= 1'b0;
      end
    end else begin
      if (inval) begin
        r_frames[wr_idx].valid <= 1'b0;
      end
      if (wr_en) begin
        r_frames[wr_idx].data[wr_off] <= wr_data;
        if (fill_done) begin
          r_frames[wr_idx].valid <= 1'b1;
          r_frames[wr_idx].tag   <= wr_tag;
        end
      end
    end
  end

  assign valid   = r_frames[rd_idx].valid;
  assign hit     = r_frames[rd_idx].valid && (r_frames[rd_idx].tag == rd_tag);
  assign rd_word = r_frames[rd_idx].data[rd_off];

endmodule

`default_nettype wire

// File: rtl/param_icache.sv
// ============================================================================
// Module   : param_icache
// Brief    : 1/2-way set-associative icache with LRU and sequential block refill.
//            Optional hit/miss counters enabled by macro ICACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_icache
  import param_icache_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2,
  parameter int ADDR_W   = 32
) (
  input  logic          CLK,
  input  logic          RST,
  param_icache_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int OFF_W  = $clog2(BLKWORDS);
  localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;

  icache_state_t     r_state, w_next;
  logic [OFF_WS-1:0] r_cnt;
  logic              r_victim;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [SETS-1:0]   r_lru;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_WS-1:0] w_off;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [WAYS-1:0]   w_way_hit;
  logic [WAYS-1:0]   w_valid;
  word_t             w_word [WAYS];
  word_t             w_word_sel;
  logic              w_hit_way;
  logic              w_victim;
  logic              w_lookup_hit;
  logic              w_miss;
  logic              w_fill_wr;
  logic              w_last;
  logic              w_unused;

  assign w_unused = &{1'b0, bus.imemaddr[1:0]};
  assign w_tag    = bus.imemaddr[ADDR_W-1 -: TAG_W];
  assign w_idx    = bus.imemaddr[OFF_W+2 +: IDX_W];
  assign w_wr_idx = (r_state == FILL) ? r_idx : w_idx;

  if (OFF_W > 0) begin : g_addr_off
    assign w_off       = bus.imemaddr[2 +: OFF_WS];
    assign w_fill_addr = {r_tag, r_idx, r_cnt, 2'b00};
  end else begin : g_addr_nooff
    assign w_off       = '0;
    assign w_fill_addr = {r_tag, r_idx, 2'b00};
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    param_icache_way #(
      .SETS     (SETS),
      .BLKWORDS (BLKWORDS),
      .TAG_W    (TAG_W)
    ) u_way (
      .clk       (CLK),
      .rst       (RST),
      .rd_idx    (w_idx),
      .rd_tag    (w_tag),
      .rd_off    (w_off),
      .wr_idx    (w_wr_idx),
      .inval     (w_miss && (w_victim == 1'(g))),
      .wr_en     (w_fill_wr && (r_victim == 1'(g))),
      .wr_off    (r_cnt),
      .wr_data   (bus.iload),
      .fill_done (w_last),
      .wr_tag    (r_tag),
      .hit       (w_way_hit[g]),
      .valid     (w_valid[g]),
      .rd_word   (w_word[g])
    );
  end

  always_comb begin
    w_hit_way  = 1'b0;
    w_word_sel = w_word[0];
    for (int w = 0; w < WAYS; w++) begin
      if (w_way_hit[w]) begin
        w_hit_way  = 1'(w);
        w_word_sel = w_word[w];
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise fall back to the LRU pointer.
  always_comb begin
    w_victim = (WAYS > 1) ? r_lru[w_idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_valid[w]) begin
        w_victim = 1'(w);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ACCESS;
      r_cnt    <= '0;
      r_victim <= 1'b0;
      r_tag    <= '0;
      r_idx    <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) begin
        r_cnt    <= '0;
        r_victim <= w_victim;
        r_tag    <= w_tag;
        r_idx    <= w_idx;
      end else if (w_fill_wr) begin
        r_cnt <= w_last ? '0 : r_cnt + OFF_WS'(1);
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_lookup_hit = 1'b0;
    w_miss       = 1'b0;
    w_fill_wr    = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      ACCESS: begin
        if (bus.imemREN) begin
          if (|w_way_hit) begin
            w_lookup_hit = 1'b1;
          end else begin
            w_miss = 1'b1;
            w_next = FILL;
          end
        end
      end
      FILL: begin
        if (!bus.iwait) begin
          w_fill_wr = 1'b1;
          if (r_cnt == OFF_WS'(BLKWORDS - 1)) begin
            w_last = 1'b1;
            w_next = ACCESS;
          end
        end
      end
      default: w_next = ACCESS;
    endcase
  end

  assign bus.ihit     = w_lookup_hit && !RST;
  assign bus.imemload = bus.ihit ? w_word_sel : '0;
  assign bus.iREN     = (r_state == FILL) && !RST;
  assign bus.iaddr    = bus.iREN ? w_fill_addr : '0;

  if (WAYS > 1) begin : g_lru
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_lru <= '0;
      end else if (w_lookup_hit) begin
        r_lru[w_idx] <= ~w_hit_way;
      end else if (w_last) begin
        r_lru[r_idx] <= ~r_victim;
      end
    end
  end else begin : g_no_lru
    assign r_lru = '0;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_lookup_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_icache.sv
// ============================================================================
// Module   : tb_param_icache
// Brief    : Self-checking bench for param_icache with a scoreboard and memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_icache;
  import param_icache_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   wait_cycles = 0;

  word_t       sb_q[$];
  logic [31:0] served[$];

  param_icache_if #(.ADDR_W(32)) bif ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  param_icache #(
    .WAYS     (2),
    .SETS     (8),
    .BLKWORDS (2),
    .ADDR_W   (32)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .bus        (bif.slave)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic word_t mem_read(input logic [31:0] a);
    if (a == 32'h40) return 32'hAAAA_0001;
    if (a == 32'h44) return 32'hAAAA_0002;
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory arbiter model: wait_cycles busy cycles before each word.
  initial begin
    int          wcnt;
    logic [31:0] prev;
    wcnt = 0;
    prev = '0;
    bif.iwait = 1'b1;
    bif.iload = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bif.iREN && !rst) begin
        if (wcnt < wait_cycles) begin
          if (wcnt == 0) prev = bif.iaddr;
          else check("iaddr_stable", bif.iaddr, prev);
          bif.iwait = 1'b1;
          bif.iload = '0;
          wcnt++;
        end else begin
          bif.iwait = 1'b0;
          bif.iload = mem_read(bif.iaddr);
          served.push_back(bif.iaddr);
          wcnt = 0;
        end
      end else begin
        bif.iwait = 1'b1;
        bif.iload = '0;
        wcnt = 0;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int exp_cycles, input bit toggle);
    int    n;
    word_t exp;
    served.delete();
    sb_q.push_back(mem_read({a[31:2], 2'b00}));
    @(posedge clk);
    #1;
    bif.imemREN  = 1'b1;
    bif.imemaddr = a;
    n = 0;
    @(negedge clk);
    check("ihit_first", {31'b0, bif.ihit}, {31'b0, exp_cycles == 0});
    if (exp_cycles == 0) check("iren_on_hit", {31'b0, bif.iREN}, 32'd0);
    while (!bif.ihit && n < 100) begin
      if (toggle) bif.imemaddr = (n >= 1 && n <= 6 && n[0]) ? (a ^ 32'hF000_0038) : a;
      @(negedge clk);
      n++;
      if (n == 1) check("iren_fill", {31'b0, bif.iREN}, 32'd1);
    end
    exp = sb_q.pop_front();
    if (!bif.ihit) begin
      check("hit_timeout", {31'b0, bif.ihit}, 32'd1);
    end else begin
      check("imemload", bif.imemload, exp);
      check("latency", n, exp_cycles);
    end
    @(posedge clk);
    #1;
    bif.imemREN = 1'b0;
  endtask

  task automatic check_served(input logic [31:0] a0, input logic [31:0] a1);
    check("served_n", served.size(), 32'd2);
    if (served.size() == 2) begin
      check("iaddr_w0", served[0], a0);
      check("iaddr_w1", served[1], a1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bif.imemREN  = 1'b1;
    bif.imemaddr = 32'h40;
    repeat (2) @(negedge clk);
    check("rst_ihit",     {31'b0, bif.ihit}, 32'd0);
    check("rst_iren",     {31'b0, bif.iREN}, 32'd0);
    check("rst_iaddr",    bif.iaddr, 32'd0);
    check("rst_imemload", bif.imemload, 32'd0);
    bif.imemREN = 1'b0;
    rst = 1'b0;

    // Cold miss, then a hit on the other word of the same block.
    fetch(32'h40, 3, 1'b0);
    check_served(32'h40, 32'h44);
    fetch(32'h44, 0, 1'b0);
`ifdef ICACHE_STATS_EN
    check("miss_count", miss_count, 32'd1);
    check("hit_count",  hit_count,  32'd2);
`endif

    // Same-set conflict: recently touched 0x80 survives, 0x40 is evicted.
    fetch(32'h80, 3, 1'b0);
    fetch(32'h80, 0, 1'b0);
    fetch(32'hC0, 3, 1'b0);
    fetch(32'h84, 0, 1'b0);
    fetch(32'h40, 3, 1'b0);
    fetch(32'hC4, 3, 1'b0);

    // Slow memory with a wandering fetch address during the fill.
    wait_cycles = 3;
    fetch(32'h104, 9, 1'b1);
    check_served(32'h100, 32'h104);
    wait_cycles = 0;

    // Reset in the middle of a fill.
    served.delete();
    @(posedge clk);
    #1;
    bif.imemREN  = 1'b1;
    bif.imemaddr = 32'h200;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_iren",  {31'b0, bif.iREN}, 32'd0);
    check("rst_mid_iaddr", bif.iaddr, 32'd0);
    bif.imemREN = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fetch(32'h200, 3, 1'b0);
    check_served(32'h200, 32'h204);
    fetch(32'h104, 3, 1'b0);
    fetch(32'h204, 0, 1'b0);

`ifdef ICACHE_STATS_EN
    @(negedge clk);
    force dut.r_hit_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_hit_count;
    fetch(32'h200, 0, 1'b0);
    @(negedge clk);
    check("hit_sat", hit_count, 32'hFFFF_FFFF);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
